arbitro_banco_registros: RTL and testbench
==========================================

// Module: arbitro_banco_registros
// PURPOSE
//   Arbitrates two requesters that write the shared M-bit register (banco_de_registros).
//   Owns that register's write port: output w_en drives w1 and w_data drives data_in1; w2 is tied 0.
//   Round-robin ownership with optional locked bursts gives both sources fair, hazard-free access.
//   Valid/ready style handshake; one write per cycle while owned.
// PARAMETERS
//   M          32  data width, equal to the register width
//   MAX_BURST  4   max consecutive writes per grant when lock is held (>=1)
// PORTS
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous reset, active-high
//   req1     in   1  requester 1 has valid data1; held until ack1 or withdrawn
//   lock1    in   1  requester 1 asks to keep ownership after this write
//   data1    in   M  requester 1 write data
//   ack1     out  1  data1 captured this edge (combinational: gnt1 & req1)
//   req2     in   1  as req1, requester 2
//   lock2    in   1  as lock1, requester 2
//   data2    in   M  requester 2 write data
//   ack2     out  1  as ack1, requester 2
//   gnt1     out  1  requester 1 owns the register (state OWN1)
//   gnt2     out  1  requester 2 owns the register (state OWN2)
//   busy     out  1  state != IDLE
//   w_en     out  1  registered write enable to register (w1)
//   w_data   out  M  registered write data to register (data_in1)
// BEHAVIOUR
//   - Reset values: state IDLE, gnt1 = gnt2 = busy = w_en = 0, w_data = 0, burst count = 0, last_owner = 2.
//     Because last_owner resets to 2, requester 1 wins the first tie.
//   - States are IDLE, OWN1 and OWN2. gntX is a registered state decode; ackX = gntX & reqX.
//   - IDLE:
//     - Only reqX high: go to OWNX at the next edge.
//     - Both high: go to the requester that is not last_owner.
//     - No request: stay in IDLE. No write ever issues from IDLE.
//   - OWNX, at each edge with ackX = 1:
//     - Capture dataX into w_data and set w_en = 1 for the following cycle.
//     - Increment the burst count.
//     - If lockX = 1 and the count after increment is < MAX_BURST: stay in OWNX.
//     - Otherwise: go to IDLE, set last_owner = X, clear the count.
//   - OWNX with reqX = 0 (withdrawn): go to IDLE with no write. Set last_owner = X and clear the count.
//   - Latency: req sampled in IDLE -> gnt next cycle -> ack in that same cycle -> w_en/w_data one cycle after ack.
//     Best case, w_en is high 2 cycles after req rises.
//   - Throughput: a locked burst writes every cycle. Every release passes through one IDLE bubble cycle.
//   - w_en is a single-cycle pulse per captured word. w_data holds its last value when w_en = 0.
//   - Only one of gnt1/gnt2 is ever high. An ack is never issued to a non-owner.
//   - lock/data of the non-owner are ignored. lockX is sampled only on an acked cycle.
//   - rst has priority over everything:
//     - A capture in the same cycle is discarded: no w_en follows.
//     - ack is forced 0 during rst.
//     - The state machine returns to reset values.
//   - Burst count width is clog2(MAX_BURST)+1. MAX_BURST = 1 means lock has no effect.
// TESTING
//   1. rst=1 for 2 cycles with req1=req2=1 -> ack1=ack2=gnt1=gnt2=w_en=0 and w_data=0 throughout.
//   2. req1=1, lock1=0, data1=32'hA5A5_0001 from IDLE:
//      - next cycle gnt1=1 and ack1=1;
//      - the cycle after, w_en=1, w_data=32'hA5A5_0001 and gnt1=0;
//      - a single write only.
//   3. req1=req2=1, lock=0, right after reset:
//      - order is req1 write, bubble, req2 write, bubble, req1 write;
//      - w_data sequence is data1, data2, data1.
//   4. MAX_BURST=4, lock1=1, req1 held for 6 words 1..6, req2=1 pending:
//      - ack1 on 4 consecutive cycles, w_data = 1, 2, 3, 4;
//      - then IDLE, then gnt2=1;
//      - words 5 and 6 are not written until req1 wins again.
//   5. gnt2=1 but req2 dropped in that cycle -> ack2=0, no w_en, IDLE next cycle; a later tie goes to requester 1.
//   6. rst=1 in the same cycle as ack1=1 with data1=32'hDEAD_BEEF:
//      - next cycle w_en=0 and w_data=0, state IDLE;
//      - after rst falls, req1 is re-granted.

Source files
------------

// File: rtl/arbitro_banco_registros_if.sv
// Bundle of requester handshakes and register write-port signals for arbitro_banco_registros.
// The slave modport is the arbiter side; the master modport drives requests and observes grants.
interface arbitro_banco_registros_if #(
  parameter int unsigned M = 32
);
  logic         req1;
  logic         lock1;
  logic [M-1:0] data1;
  logic         ack1;
  logic         req2;
  logic         lock2;
  logic [M-1:0] data2;
  logic         ack2;
  logic         gnt1;
  logic         gnt2;
  logic         busy;
  logic         w_en;
  logic [M-1:0] w_data;

  modport slave (
    input  req1, lock1, data1, req2, lock2, data2,
    output ack1, ack2, gnt1, gnt2, busy, w_en, w_data
  );

  modport master (
    output req1, lock1, data1, req2, lock2, data2,
    input  ack1, ack2, gnt1, gnt2, busy, w_en, w_data
  );
endinterface

// File: rtl/arbitro_banco_registros.sv
// Round-robin owner of the shared register's write port, with optional locked bursts
// of up to MAX_BURST words. Every release passes through one IDLE cycle.
module arbitro_banco_registros #(
  parameter int unsigned M         = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                       clk,
  input logic                       rst,
  arbitro_banco_registros_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MaxBurst = CW'(MAX_BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN1 = 2'd1;
  localparam logic [1:0] OWN2 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  // 1 when requester 2 was the last owner, so requester 1 wins the next tie.
  logic          last2_q, last2_d;
  logic          w_en_q, w_en_d;
  logic [M-1:0]  w_data_q, w_data_d;
  logic          gnt1, gnt2, ack1, ack2;

  assign gnt1    = (state_q == OWN1);
  assign gnt2    = (state_q == OWN2);
  assign ack1    = gnt1 & bus.req1 & ~rst;
  assign ack2    = gnt2 & bus.req2 & ~rst;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last2_d  = last2_q;
    w_en_d   = 1'b0;
    w_data_d = w_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req1 && bus.req2) begin
          state_d = last2_q ? OWN1 : OWN2;
        end else if (bus.req1) begin
          state_d = OWN1;
        end else if (bus.req2) begin
          state_d = OWN2;
        end
      end
      OWN1: begin
        if (ack1) begin
          w_en_d   = 1'b1;
          w_data_d = bus.data1;
          if (bus.lock1 && (cnt_inc < MaxBurst)) begin
            cnt_d = cnt_inc;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            last2_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          last2_d = 1'b0;
        end
      end
      OWN2: begin
        if (ack2) begin
          w_en_d   = 1'b1;
          w_data_d = bus.data2;
          if (bus.lock2 && (cnt_inc < MaxBurst)) begin
            cnt_d = cnt_inc;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            last2_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          last2_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last2_q  <= 1'b1;
      w_en_q   <= 1'b0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last2_q  <= last2_d;
      w_en_q   <= w_en_d;
      w_data_q <= w_data_d;
    end
  end

  assign bus.gnt1   = gnt1;
  assign bus.gnt2   = gnt2;
  assign bus.ack1   = ack1;
  assign bus.ack2   = ack2;
  assign bus.busy   = (state_q != IDLE);
  assign bus.w_en   = w_en_q;
  assign bus.w_data = w_data_q;

endmodule

// File: tb/tb_arbitro_banco_registros.sv
// Directed bench for arbitro_banco_registros: expected writes go into a queue that a
// negedge monitor drains whenever w_en is high; handshake timing is checked inline.
module tb_arbitro_banco_registros;
  localparam int unsigned M = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [M-1:0] exp_q[$];

  arbitro_banco_registros_if #(.M(M)) bus ();

  arbitro_banco_registros #(.M(M), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Write monitor: every w_en pulse must match the next expected word.
  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write: got unexpected w_data %h expected no write at %0t",
                 bus.w_data, $time);
      end else begin
        logic [M-1:0] e;
        e = exp_q.pop_front();
        if (bus.w_data !== e) begin
          bad++;
          $display("FAIL write: got w_data %h expected %h at %0t", bus.w_data, e, $time);
        end
      end
    end
  end

  initial begin
    bus.req1 = 1'b1; bus.req2 = 1'b1; bus.lock1 = 1'b0; bus.lock2 = 1'b0;
    bus.data1 = '0;  bus.data2 = '0;

    // 1: reset with both requests high
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      chk("rst_ack1", M'(bus.ack1), 0);
      chk("rst_ack2", M'(bus.ack2), 0);
      chk("rst_gnt1", M'(bus.gnt1), 0);
      chk("rst_gnt2", M'(bus.gnt2), 0);
      chk("rst_w_en", M'(bus.w_en), 0);
      chk("rst_w_data", bus.w_data, 0);
    end
    rst = 1'b0; bus.req1 = 1'b0; bus.req2 = 1'b0;
    tick();

    // 2: single unlocked write from requester 1
    bus.req1 = 1'b1; bus.data1 = 32'hA5A5_0001; exp_q.push_back(32'hA5A5_0001);
    settle();
    chk("t2_idle_gnt1", M'(bus.gnt1), 0);
    tick(); settle();
    chk("t2_gnt1", M'(bus.gnt1), 1);
    chk("t2_ack1", M'(bus.ack1), 1);
    tick(); bus.req1 = 1'b0; settle();
    chk("t2_w_en", M'(bus.w_en), 1);
    chk("t2_w_data", bus.w_data, 32'hA5A5_0001);
    chk("t2_gnt1_off", M'(bus.gnt1), 0);
    tick(); settle();
    chk("t2_single", M'(bus.w_en), 0);

    // 3: tie right after reset alternates 1, 2, 1
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req1 = 1'b1; bus.req2 = 1'b1; bus.data1 = 32'h11; bus.data2 = 32'h22;
    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h11);
    tick(); settle();
    chk("t3_gnt1_a", M'(bus.gnt1), 1);
    tick(); settle();
    chk("t3_bubble1", M'(bus.busy), 0);
    tick(); settle();
    chk("t3_gnt2", M'(bus.gnt2), 1);
    chk("t3_ack2", M'(bus.ack2), 1);
    tick(); settle();
    chk("t3_bubble2", M'(bus.busy), 0);
    tick(); settle();
    chk("t3_gnt1_b", M'(bus.gnt1), 1);
    tick(); bus.req1 = 1'b0; bus.req2 = 1'b0;
    tick(); tick();

    // 4: locked burst capped at 4 words, then requester 2, then the rest
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.data1 = 32'd1;
    bus.req2 = 1'b1; bus.data2 = 32'h200;
    for (int k = 1; k <= 4; k++) exp_q.push_back(M'(k));
    exp_q.push_back(32'h200); exp_q.push_back(32'd5); exp_q.push_back(32'd6);
    tick();
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("t4_burst_ack1", M'(bus.ack1), 1);
      tick(); bus.data1 = M'(k + 1);
    end
    settle();
    chk("t4_bubble_gnt1", M'(bus.gnt1), 0);
    chk("t4_bubble_gnt2", M'(bus.gnt2), 0);
    tick(); settle();
    chk("t4_gnt2", M'(bus.gnt2), 1);
    chk("t4_no_ack1", M'(bus.ack1), 0);
    tick(); bus.req2 = 1'b0; settle();
    chk("t4_gnt2_off", M'(bus.gnt2), 0);
    tick(); settle();
    chk("t4_regrant1", M'(bus.ack1), 1);
    tick(); bus.data1 = 32'd6; bus.lock1 = 1'b0; settle();
    chk("t4_still_own1", M'(bus.gnt1), 1);
    tick(); bus.req1 = 1'b0; settle();
    chk("t4_release", M'(bus.busy), 0);
    tick(); tick();

    // 5: owner withdraws, then a tie goes to requester 1
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req2 = 1'b1; bus.data2 = 32'h55;
    tick(); bus.req2 = 1'b0; settle();
    chk("t5_gnt2", M'(bus.gnt2), 1);
    chk("t5_ack2", M'(bus.ack2), 0);
    tick(); settle();
    chk("t5_idle", M'(bus.busy), 0);
    chk("t5_no_w_en", M'(bus.w_en), 0);
    bus.req1 = 1'b1; bus.req2 = 1'b1; bus.data1 = 32'h77; exp_q.push_back(32'h77);
    tick(); settle();
    chk("t5_tie_gnt1", M'(bus.gnt1), 1);
    tick(); bus.req1 = 1'b0; bus.req2 = 1'b0;
    tick(); tick();

    // 6: reset coinciding with an ack discards the capture
    bus.req1 = 1'b1; bus.data1 = 32'hDEAD_BEEF;
    tick(); settle();
    chk("t6_ack1", M'(bus.ack1), 1);
    rst = 1'b1; settle();
    chk("t6_ack_forced", M'(bus.ack1), 0);
    tick(); rst = 1'b0; settle();
    chk("t6_w_en", M'(bus.w_en), 0);
    chk("t6_w_data", bus.w_data, 0);
    chk("t6_idle", M'(bus.busy), 0);
    exp_q.push_back(32'hDEAD_BEEF);
    tick(); settle();
    chk("t6_regrant", M'(bus.gnt1), 1);
    tick(); bus.req1 = 1'b0;
    tick(); tick(); tick();

    chk("queue_drained", M'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
